vending_ctrl_param: RTL and testbench

VENDING_CTRL_PARAM -- requirements
Module: vending_ctrl_param

---
 rtl/vending_pkg.sv | 32 +++
 rtl/vending_ctrl_param_if.sv | 25 ++
 rtl/vending_change_gen.sv | 24 ++
 rtl/vending_ctrl_param.sv | 109 ++++++++++
 tb/tb_vending_ctrl_param.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared encodings for the vending controller: FSM states, coin codes, change codes.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COLLECT  = 2'b01,
    DISPENSE = 2'b10,
    CHANGE   = 2'b11
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  // Coin code to value in 5-rs units.
  function automatic logic [2:0] coin_units(input logic [1:0] coin);
    logic [2:0] units;
    case (coin)
      COIN_5:  units = 3'd1;
      COIN_10: units = 3'd2;
      COIN_20: units = 3'd4;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vending_ctrl_param_if.sv
// User/dispenser-facing signal bundle of the vending controller.
interface vending_ctrl_param_if #(
  parameter int unsigned CREDIT_W = 5
) ();

  logic [1:0]          in;
  logic                cancel;
  logic                vend_ack;
  logic                out;
  logic [1:0]          change;
  logic                reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output in, cancel, vend_ack,
    input  out, change, reject, credit, busy
  );

  modport slave (
    input  in, cancel, vend_ack,
    output out, change, reject, credit, busy
  );

endinterface

// File: rtl/vending_change_gen.sv
// Picks the largest returnable coin for the remaining credit and how much it removes.
module vending_change_gen
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W = 5
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          change_c,
  output logic [1:0]          dec_c
);

  always_comb begin
    change_c = CHG_NONE;
    dec_c    = 2'd0;
    if (credit >= CREDIT_W'(2)) begin
      change_c = CHG_10;
      dec_c    = 2'd2;
    end else if (credit == CREDIT_W'(1)) begin
      change_c = CHG_5;
      dec_c    = 2'd1;
    end
  end

endmodule

// File: rtl/vending_ctrl_param.sv
// Coin-operated vending controller: collects credit, requests dispense at PRICE,
// refunds leftover credit one coin per cycle. All outputs are registered.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 5,
  parameter int unsigned PRICE      = 3,
  parameter int unsigned MAX_CREDIT = 8
) (
  input logic                 clk,
  input logic                 rst,
  vending_ctrl_param_if.slave bus
);

  // One extra bit so credit + coin can never wrap before the ceiling check.
  localparam int unsigned SUM_W = CREDIT_W + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [1:0]          change_q, change_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic [SUM_W-1:0]    sum;
  logic                coin_valid;
  logic [1:0]          gen_change;
  logic [1:0]          gen_dec;

  vending_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .credit   (credit_q),
    .change_c (gen_change),
    .dec_c    (gen_dec)
  );

  assign coin_valid = (bus.in != COIN_NONE);
  assign sum        = SUM_W'(credit_q) + SUM_W'(coin_units(bus.in));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = CHG_NONE;
    reject_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        // Cancel wins over a coin offered in the same cycle.
        if (bus.cancel) begin
          reject_d = coin_valid;
          state_d  = (credit_q != '0) ? CHANGE : IDLE;
        end else if (coin_valid) begin
          if (sum > SUM_W'(MAX_CREDIT)) begin
            reject_d = 1'b1;
          end else if (sum >= SUM_W'(PRICE)) begin
            credit_d = CREDIT_W'(sum - SUM_W'(PRICE));
            state_d  = DISPENSE;
          end else begin
            credit_d = CREDIT_W'(sum);
            state_d  = COLLECT;
          end
        end
      end
      DISPENSE: begin
        reject_d = coin_valid;
        if (bus.vend_ack) begin
          state_d = (credit_q != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        reject_d = coin_valid;
        if (gen_dec == 2'd0) begin
          state_d = IDLE;
        end else begin
          change_d = gen_change;
          credit_d = credit_q - CREDIT_W'(gen_dec);
        end
      end
      default: state_d = IDLE;
    endcase
    out_d  = (state_d == DISPENSE);
    busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      out_q    <= 1'b0;
      change_q <= CHG_NONE;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      out_q    <= out_d;
      change_q <= change_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.change = change_q;
  assign bus.reject = reject_q;
  assign bus.credit = credit_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: two instances (PRICE=3 and PRICE=8, MAX_CREDIT=8)
// driven in lockstep, scored against a cycle model through expectation queues.
module tb_vending_ctrl_param;

  typedef struct {
    int st;
    int cr;
    int out;
    int chg;
    int rej;
    int busy;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  exp_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];

  vending_ctrl_param_if #(.CREDIT_W(5)) ifa ();
  vending_ctrl_param_if #(.CREDIT_W(5)) ifb ();

  vending_ctrl_param #(.CREDIT_W(5), .PRICE(3), .MAX_CREDIT(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  vending_ctrl_param #(.CREDIT_W(5), .PRICE(8), .MAX_CREDIT(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour: state after one active edge given the sampled inputs.
  function automatic exp_t model_step(input exp_t m, input int price, input int maxc,
                                      input logic [1:0] cin, input logic can, input logic ack);
    exp_t n;
    int   v;
    n     = m;
    n.chg = 0;
    n.rej = 0;
    v = (cin == 2'b01) ? 1 : (cin == 2'b10) ? 2 : (cin == 2'b11) ? 4 : 0;
    if (m.st == 0 || m.st == 1) begin
      if (can) begin
        n.rej = (v != 0) ? 1 : 0;
        n.st  = (m.cr > 0) ? 3 : 0;
      end else if (v != 0) begin
        if (m.cr + v > maxc) n.rej = 1;
        else if (m.cr + v >= price) begin
          n.cr = m.cr + v - price;
          n.st = 2;
        end else begin
          n.cr = m.cr + v;
          n.st = 1;
        end
      end
    end else begin
      n.rej = (v != 0) ? 1 : 0;
      if (m.st == 2) begin
        if (ack) n.st = (m.cr > 0) ? 3 : 0;
      end else if (m.cr == 0) begin
        n.st = 0;
      end else begin
        n.chg = (m.cr >= 2) ? 2 : 1;
        n.cr  = m.cr - n.chg;
      end
    end
    n.out  = (n.st == 2) ? 1 : 0;
    n.busy = (n.st >= 2) ? 1 : 0;
    return n;
  endfunction

  task automatic score(input string nm, input exp_t e, input logic o, input logic [1:0] ch,
                       input logic rj, input logic [4:0] cr, input logic bz);
    check_eq({nm, ".out"}, 32'(o), 32'(e.out));
    check_eq({nm, ".change"}, 32'(ch), 32'(e.chg));
    check_eq({nm, ".reject"}, 32'(rj), 32'(e.rej));
    check_eq({nm, ".credit"}, 32'(cr), 32'(e.cr));
    check_eq({nm, ".busy"}, 32'(bz), 32'(e.busy));
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, compare after the edge.
  task automatic tick(input logic [1:0] cin, input logic can, input logic ack);
    exp_t e;
    ifa.in = cin; ifa.cancel = can; ifa.vend_ack = ack;
    ifb.in = cin; ifb.cancel = can; ifb.vend_ack = ack;
    ma = model_step(ma, 3, 8, cin, can, ack);
    mb = model_step(mb, 8, 8, cin, can, ack);
    qa.push_back(ma);
    qb.push_back(mb);
    @(negedge clk);
    if (qa.size() == 0 || qb.size() == 0) begin
      check_eq("queue_empty", 32'(qa.size()), 32'd1);
    end else begin
      e = qa.pop_front();
      score("a", e, ifa.out, ifa.change, ifa.reject, ifa.credit, ifa.busy);
      e = qb.pop_front();
      score("b", e, ifb.out, ifb.change, ifb.reject, ifb.credit, ifb.busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".a.credit"}, 32'(ifa.credit), 32'd0);
    check_eq({tag, ".a.change"}, 32'(ifa.change), 32'd0);
    check_eq({tag, ".a.out"}, 32'(ifa.out), 32'd0);
    check_eq({tag, ".a.reject"}, 32'(ifa.reject), 32'd0);
    check_eq({tag, ".a.busy"}, 32'(ifa.busy), 32'd0);
    check_eq({tag, ".b.credit"}, 32'(ifb.credit), 32'd0);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    ma = '{0, 0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0, 0};
    ifa.in = 2'b00; ifa.cancel = 1'b0; ifa.vend_ack = 1'b0;
    ifb.in = 2'b00; ifb.cancel = 1'b0; ifb.vend_ack = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    // No clock edge has occurred yet: outputs must already be cleared.
    #2 check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;

    // Three 5-rs coins buy one item with nothing left over.
    tick(2'b01, 1'b0, 1'b0);
    check_eq("r033.credit1", 32'(ifa.credit), 32'd1);
    tick(2'b01, 1'b0, 1'b0);
    check_eq("r033.credit2", 32'(ifa.credit), 32'd2);
    tick(2'b01, 1'b0, 1'b0);
    check_eq("r033.out", 32'(ifa.out), 32'd1);
    check_eq("r033.credit0", 32'(ifa.credit), 32'd0);
    tick(2'b00, 1'b0, 1'b1);
    check_eq("r033.out_clr", 32'(ifa.out), 32'd0);
    check_eq("r033.busy", 32'(ifa.busy), 32'd0);
    check_eq("b.ack_ignored", 32'(ifb.credit), 32'd3);
    tick(2'b00, 1'b1, 1'b0);
    idle_ticks(3);

    // 20-rs coin: dispense with 5 rs change after the ack.
    tick(2'b11, 1'b0, 1'b0);
    check_eq("r034.out", 32'(ifa.out), 32'd1);
    check_eq("r034.credit", 32'(ifa.credit), 32'd1);
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b0);
    check_eq("r034.change", 32'(ifa.change), 32'd1);
    tick(2'b00, 1'b0, 1'b0);
    check_eq("r034.idle", 32'(ifa.busy), 32'd0);

    // Over-ceiling coin on the PRICE=8 instance: 4 + 2 + 4 > 8.
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    check_eq("r036.reject", 32'(ifb.reject), 32'd1);
    check_eq("r036.credit", 32'(ifb.credit), 32'd6);
    tick(2'b00, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b1);
    idle_ticks(5);

    // Coin then cancel: refund the 5 rs.
    tick(2'b01, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    check_eq("r035.change", 32'(ifa.change), 32'd1);
    check_eq("r035.out", 32'(ifa.out), 32'd0);
    idle_ticks(2);

    // Cancel with a coin in the same cycle: coin rejected, credit refunded.
    tick(2'b01, 1'b0, 1'b0);
    tick(2'b10, 1'b1, 1'b0);
    check_eq("r037.reject", 32'(ifa.reject), 32'd1);
    tick(2'b00, 1'b0, 1'b0);
    check_eq("r037.change", 32'(ifa.change), 32'd1);
    check_eq("r037.credit", 32'(ifa.credit), 32'd0);
    tick(2'b00, 1'b1, 1'b0);
    idle_ticks(6);

    // Reset while refunding 15 rs: remaining credit is discarded.
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    check_eq("r032.credit3", 32'(ifa.credit), 32'd3);
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b0);
    check_eq("r032.mid_change", 32'(ifa.change), 32'd2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("r032.rst");
    ma = '{0, 0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0, 0};
    @(negedge clk);
    rst = 1'b0;
    idle_ticks(3);

    // Random traffic with occasional cancels and acks.
    for (int i = 0; i < 400; i++) begin
      tick(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end
    tick(2'b00, 1'b1, 1'b1);
    idle_ticks(8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
